// File: rtl/tape_rec_pkg.sv
// rtl/tape_rec_pkg.sv - shared types and constants for the cassette save recorder
package tape_rec_pkg;

    localparam int PERIOD_W = 10;
    localparam logic [PERIOD_W-1:0] PERIOD_SAT     = 10'd1023;
    localparam logic [PERIOD_W-1:0] PERIOD_PRE_SAT = 10'd1022;

    typedef enum logic [1:0] {HUNT, DATA, PARITY, STOP} rec_state_e;
    typedef enum logic [1:0] {GLITCH, ONE, ZERO, GAP} bit_class_e;

    function automatic bit_class_e classify_period(
        input logic [PERIOD_W-1:0] period,
        input int                  min_us,
        input int                  thresh_us,
        input int                  max_us
    );
        int p;
        p = int'(period);
        if (p < min_us)         return GLITCH;
        else if (p < thresh_us) return ONE;
        else if (p <= max_us)   return ZERO;
        else                    return GAP;
    endfunction

endpackage

// File: rtl/tape_recorder_if.sv
// rtl/tape_recorder_if.sv - save-buffer write port and recorder status bundle
interface tape_recorder_if #(
    parameter int AW = 16
);
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic [AW:0]   byte_count;
    logic          parity_err;
    logic          framing_err;
    logic          overflow;
    logic          busy;

    modport master (
        output wr_addr, wr_data, wr_en, byte_count,
        output parity_err, framing_err, overflow, busy
    );

    modport slave (
        input wr_addr, wr_data, wr_en, byte_count,
        input parity_err, framing_err, overflow, busy
    );
endinterface

// File: rtl/tape_period_meter.sv
// rtl/tape_period_meter.sv - synchroniser, microsecond period counter and edge classifier
module tape_period_meter
    import tape_rec_pkg::*;
#(
    parameter int CLK_HZ    = 24000000,
    parameter int MIN_US    = 150,
    parameter int THRESH_US = 520,
    parameter int MAX_US    = 1000
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic tape_out,
    input  logic relay,
    output logic bit_strobe,
    output logic bit_val,
    output logic gap_strobe
);
    localparam int PRESCALE = CLK_HZ / 1000000;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [1:0]          sync_q;
    logic                prev_q;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    bit_class_e          cls_q, cls_now;
    logic                vld_q, gap1_q;
    logic                bit_strobe_q, bit_val_q, gap_strobe_q;
    logic                rise, tick, clr_cnt, sat_hit;

    assign rise    = relay && sync_q[1] && !prev_q;
    assign tick    = (presc_q == PW'(PRESCALE - 1));
    assign cls_now = classify_period(cnt_q, MIN_US, THRESH_US, MAX_US);
    assign clr_cnt = rise && (cls_now != GLITCH);
    // Reaching saturation is reported like a gap so a stalled frame is aborted.
    assign sat_hit = relay && tick && !clr_cnt && (cnt_q == PERIOD_PRE_SAT);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        if (!relay)
            cnt_d = PERIOD_SAT;
        else if (clr_cnt)
            cnt_d = '0;
        else if (tick && (cnt_q != PERIOD_SAT))
            cnt_d = cnt_q + PERIOD_W'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            presc_q      <= '0;
            cnt_q        <= PERIOD_SAT;
            cls_q        <= GAP;
            vld_q        <= 1'b0;
            gap1_q       <= 1'b0;
            bit_strobe_q <= 1'b0;
            bit_val_q    <= 1'b0;
            gap_strobe_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], tape_out};
            prev_q       <= sync_q[1];
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            cls_q        <= cls_now;
            vld_q        <= rise;
            gap1_q       <= (rise && (cls_now == GAP)) || sat_hit;
            bit_strobe_q <= relay && vld_q && ((cls_q == ONE) || (cls_q == ZERO));
            bit_val_q    <= (cls_q == ONE);
            gap_strobe_q <= relay && gap1_q;
        end
    end

    assign bit_strobe = bit_strobe_q;
    assign bit_val    = bit_val_q;
    assign gap_strobe = gap_strobe_q;

endmodule

// File: rtl/tape_recorder.sv
// rtl/tape_recorder.sv - decodes Oric cassette FSK output into bytes for the save buffer
module tape_recorder
    import tape_rec_pkg::*;
#(
    parameter int CLK_HZ    = 24000000,
    parameter int AW        = 16,
    parameter int MIN_US    = 150,
    parameter int THRESH_US = 520,
    parameter int MAX_US    = 1000
) (
    input  logic             clk_sys,
    input  logic             RESET,
    input  logic             tape_out,
    input  logic             relay,
    input  logic             clear,
    tape_recorder_if.master  bus
);
    logic bit_strobe, bit_val, gap_strobe;

    rec_state_e    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [AW:0]   count_q, count_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    tape_period_meter #(
        .CLK_HZ    (CLK_HZ),
        .MIN_US    (MIN_US),
        .THRESH_US (THRESH_US),
        .MAX_US    (MAX_US)
    ) u_meter (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .tape_out   (tape_out),
        .relay      (relay),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val),
        .gap_strobe (gap_strobe)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;

        if (relay && gap_strobe && (state_q != HUNT)) begin
            ferr_d  = 1'b1;
            state_d = HUNT;
        end else if (relay && bit_strobe) begin
            case (state_q)
                HUNT: begin
                    if (!bit_val) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {bit_val, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    // Odd parity: data ones plus parity bit must be odd.
                    if (!((^shift_q) ^ bit_val))
                        perr_d = 1'b1;
                    if (count_q[AW]) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q[AW-1:0];
                        wr_data_d = shift_q;
                        count_d   = count_q + {{AW{1'b0}}, 1'b1};
                    end
                    state_d = STOP;
                end
                STOP: begin
                    if (!bit_val)
                        ferr_d = 1'b1;
                    state_d = HUNT;
                end
            endcase
        end

        if (!relay)
            state_d = HUNT;

        if (clear) begin
            state_d = HUNT;
            wr_en_d = 1'b0;
            count_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q   <= HUNT;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            count_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.byte_count  = count_q;
    assign bus.parity_err  = perr_q;
    assign bus.framing_err = ferr_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = (state_q != HUNT);

endmodule

// File: tb/tb_tape_recorder.sv
// tb/tb_tape_recorder.sv - self-checking bench for tape_recorder
module tb_tape_recorder;
    localparam int CLK_HZ = 1000000;
    localparam int AW     = 2;
    localparam int CAP    = 1 << AW;

    logic clk_sys = 1'b0;
    logic RESET, tape_out, relay, clear;

    always #5 clk_sys = ~clk_sys;

    tape_recorder_if #(.AW(AW)) bus ();

    tape_recorder #(
        .CLK_HZ    (CLK_HZ),
        .AW        (AW),
        .MIN_US    (150),
        .THRESH_US (520),
        .MAX_US    (1000)
    ) dut (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .tape_out (tape_out),
        .relay    (relay),
        .clear    (clear),
        .bus      (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        bit         par;
        bit         stop;
        bit         preamble;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    wr_t  mon_w;
    vec_t vecs[3];
    int   exp_count;
    bit   exp_perr, exp_ferr, exp_ovf;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(negedge clk_sys) begin
        if (bus.wr_en === 1'b1) begin
            mon_w.addr = bus.wr_addr;
            mon_w.data = bus.wr_data;
            got_q.push_back(mon_w);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic bit odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Randomised cell lengths kept clear of the class boundaries.
    function automatic int per(input bit b);
        return b ? int'($urandom_range(505, 200)) : int'($urandom_range(800, 535));
    endfunction

    task automatic pulse(input int p);
        tape_out = 1'b1; wait_cyc(p / 2);
        tape_out = 1'b0; wait_cyc(p - p / 2);
    endtask

    task automatic glitch_pulse(input int p);
        tape_out = 1'b1; wait_cyc(30);
        tape_out = 1'b0; wait_cyc(20);
        tape_out = 1'b1; wait_cyc(100);
        tape_out = 1'b0; wait_cyc(p - 150);
    endtask

    task automatic send_bit(input bit b);
        pulse(per(b));
    endtask

    task automatic close_edge();
        tape_out = 1'b1; wait_cyc(60);
        tape_out = 1'b0; wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        close_edge();
    endtask

    task automatic pulse_clear();
        clear = 1'b1; wait_cyc(1);
        clear = 1'b0; wait_cyc(1);
    endtask

    task automatic toggle_relay();
        relay = 1'b0; wait_cyc(3);
        relay = 1'b1; wait_cyc(3);
    endtask

    task automatic model_clear();
        exp_count = 0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        wr_t w;
        if (exp_count < CAP) begin
            w.addr = exp_count[AW-1:0];
            w.data = d;
            exp_q.push_back(w);
            exp_count++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic check_state(input string name);
        chk({name, ".count"}, 32'(bus.byte_count), exp_count);
        chk({name, ".perr"}, 32'(bus.parity_err), 32'(exp_perr));
        chk({name, ".ferr"}, 32'(bus.framing_err), 32'(exp_ferr));
        chk({name, ".ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s.addr%0d", name, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            chk($sformatf("%s.data%0d", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, ".wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({name, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
        chk({name, ".wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({name, ".count"}, 32'(bus.byte_count), 32'd0);
        chk({name, ".perr"}, 32'(bus.parity_err), 32'd0);
        chk({name, ".ferr"}, 32'(bus.framing_err), 32'd0);
        chk({name, ".ovf"}, 32'(bus.overflow), 32'd0);
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rnd;
        bit         rp;

        RESET = 1'b1; relay = 1'b0; clear = 1'b0; tape_out = 1'b0;
        wait_cyc(4);
        check_zero("reset");
        RESET = 1'b0;
        model_clear();
        relay = 1'b1;
        wait_cyc(3);

        rnd = 8'($urandom);
        rp  = 1'($urandom_range(1, 0));
        vecs[0] = '{8'h16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{rnd, rp, 1'b0, 1'b0, (rp != odd_par(rnd)), 1'b1};

        for (int v = 0; v < 3; v++) begin
            pulse_clear();
            model_clear();
            toggle_relay();
            if (vecs[v].preamble)
                for (int k = 0; k < 11; k++) send_bit(1'b1);
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            close_edge();
            wait_cyc(10);
            model_byte(vecs[v].data);
            exp_perr = vecs[v].exp_perr;
            exp_ferr = vecs[v].exp_ferr;
            check_state($sformatf("vec%0d", v));
        end

        // Glitch inside data bit 3 of 0x24.
        pulse_clear();
        model_clear();
        toggle_relay();
        rnd = 8'h24;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) glitch_pulse(per(rnd[i]));
            else        send_bit(rnd[i]);
        end
        send_bit(odd_par(rnd));
        send_bit(1'b1);
        close_edge();
        wait_cyc(10);
        model_byte(8'h24);
        check_state("glitch");

        // Relay dropped mid-byte keeps buffer, discards partial byte silently.
        toggle_relay();
        send_partial(8'hAA, 3);
        wait_cyc(10);
        chk("relay.busy_mid", 32'(bus.busy), 32'd1);
        relay = 1'b0;
        wait_cyc(3);
        chk("relay.busy_off", 32'(bus.busy), 32'd0);
        relay = 1'b1;
        wait_cyc(3);
        send_frame(8'h55, odd_par(8'h55), 1'b1);
        close_edge();
        wait_cyc(10);
        model_byte(8'h55);
        check_state("relay");

        // Reset arriving mid-byte.
        toggle_relay();
        send_partial(8'hAA, 3);
        wait_cyc(10);
        chk("rst.busy_mid", 32'(bus.busy), 32'd1);
        RESET = 1'b1;
        wait_cyc(2);
        check_zero("rst");
        RESET = 1'b0;
        model_clear();
        wait_cyc(2);
        check_state("rst_after");

        // Long silence after the 4th data bit.
        pulse_clear();
        model_clear();
        toggle_relay();
        send_partial(8'h16, 4);
        wait_cyc(1500);
        chk("gap.ferr_early", 32'(bus.framing_err), 32'd1);
        chk("gap.nwr_early", got_q.size(), 32'd0);
        send_frame(8'h16, odd_par(8'h16), 1'b1);
        close_edge();
        wait_cyc(10);
        exp_ferr = 1'b1;
        model_byte(8'h16);
        check_state("gap");

        // Five bytes into a four-byte buffer, then clear.
        pulse_clear();
        model_clear();
        toggle_relay();
        for (int b = 1; b <= 5; b++) begin
            rnd = 8'(b);
            send_frame(rnd, odd_par(rnd), 1'b1);
        end
        close_edge();
        wait_cyc(10);
        for (int b = 1; b <= 5; b++) model_byte(8'(b));
        check_state("ovf");
        pulse_clear();
        model_clear();
        wait_cyc(2);
        check_state("clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
